// File: rtl/ifu_fetch_arb.sv
// ifu_fetch_arb: shares one instruction-fetch read bus (AR + R) among
// NUM_REQ fetch units. Round-robin grant, a single outstanding transaction,
// and per-requester flush that drains and discards the owner's response.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_ar            packed request addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ar_valid      address request valid per requester
//   req_ar_ready      address accepted (one-hot or zero, combinational in IDLE)
//   req_r_valid       response valid to the owner (one-hot or zero)
//   req_r_ready       requester ready for response
//   req_r_data        response line, broadcast to all requesters
//   req_flush         cancel in-flight fetch of requester i
//   bus_ar/_valid     registered bus read address channel
//   bus_ar_ready      bus address ready
//   bus_r_valid/data  bus read data channel
//   bus_r_ready       bus data ready
//   grant_id          index of current or last owner
//   busy              transaction in flight
module ifu_fetch_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned REQ_BITS   = 2,
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_ar,
    input  logic [NUM_REQ-1:0]            req_ar_valid,
    output logic [NUM_REQ-1:0]            req_ar_ready,
    output logic [NUM_REQ-1:0]            req_r_valid,
    input  logic [NUM_REQ-1:0]            req_r_ready,
    output logic [DATA_WIDTH-1:0]         req_r_data,
    input  logic [NUM_REQ-1:0]            req_flush,
    output logic [ADDR_WIDTH-1:0]         bus_ar,
    output logic                          bus_ar_valid,
    input  logic                          bus_ar_ready,
    input  logic                          bus_r_valid,
    output logic                          bus_r_ready,
    input  logic [DATA_WIDTH-1:0]         bus_r_data,
    output logic [REQ_BITS-1:0]           grant_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  r_state,        w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_bus_ar,       w_bus_ar_nxt;
    logic                    r_bus_ar_valid, w_bus_ar_valid_nxt;
    logic [REQ_BITS-1:0]     r_grant_id,     w_grant_id_nxt;
    logic [REQ_BITS-1:0]     r_last_grant,   w_last_grant_nxt;
    logic                    r_drop,         w_drop_nxt;

    logic                    w_win_found;
    logic [REQ_BITS-1:0]     w_win_idx;
    logic [REQ_BITS-1:0]     w_cand;
    logic                    w_owner_flush;
    logic                    w_bus_r_ready;

    // Round-robin search starting after last_grant; scanning from the far end
    // down lets the nearest valid requester overwrite earlier candidates.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = int'(NUM_REQ); k > 0; k--) begin
            w_cand = REQ_BITS'((int'(r_last_grant) + k) % int'(NUM_REQ));
            if (req_ar_valid[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    assign w_owner_flush = req_flush[r_grant_id];

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt        = r_state;
        w_bus_ar_nxt       = r_bus_ar;
        w_bus_ar_valid_nxt = r_bus_ar_valid;
        w_grant_id_nxt     = r_grant_id;
        w_last_grant_nxt   = r_last_grant;
        w_drop_nxt         = r_drop;
        req_ar_ready       = '0;
        req_r_valid        = '0;
        w_bus_r_ready      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    req_ar_ready[w_win_idx] = 1'b1;
                    w_bus_ar_nxt       = req_ar[32'(w_win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    w_bus_ar_valid_nxt = 1'b1;
                    w_grant_id_nxt     = w_win_idx;
                    w_last_grant_nxt   = w_win_idx;
                    // A flush raised in the grant cycle already cancels this fetch.
                    w_drop_nxt         = req_flush[w_win_idx];
                    w_state_nxt        = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_owner_flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (bus_ar_ready) begin
                    w_bus_ar_valid_nxt = 1'b0;
                    w_state_nxt        = S_DATA;
                end
            end
            S_DATA: begin
                // Flushed responses are still drained from the bus, just never shown.
                req_r_valid[r_grant_id] = bus_r_valid & ~r_drop & ~w_owner_flush;
                w_bus_r_ready = r_drop | w_owner_flush | req_r_ready[r_grant_id];
                if (w_owner_flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (bus_r_valid && w_bus_r_ready) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt        = S_IDLE;
                w_bus_ar_valid_nxt = 1'b0;
                w_drop_nxt         = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_bus_ar       <= '0;
            r_bus_ar_valid <= 1'b0;
            r_grant_id     <= '0;
            r_last_grant   <= REQ_BITS'(NUM_REQ - 1);
            r_drop         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bus_ar       <= w_bus_ar_nxt;
            r_bus_ar_valid <= w_bus_ar_valid_nxt;
            r_grant_id     <= w_grant_id_nxt;
            r_last_grant   <= w_last_grant_nxt;
            r_drop         <= w_drop_nxt;
        end
    end

    assign bus_ar       = r_bus_ar;
    assign bus_ar_valid = r_bus_ar_valid;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state != S_IDLE);
    assign bus_r_ready  = w_bus_r_ready;
    assign req_r_data   = (r_state == S_DATA) ? bus_r_data : '0;

endmodule

// File: tb/tb_ifu_fetch_arb.sv
// tb_ifu_fetch_arb: directed scenarios followed by randomized traffic checked
// against a transaction-level model of the shared fetch bus.
module tb_ifu_fetch_arb;

    localparam int N  = 4;
    localparam int RB = 2;
    localparam int AW = 48;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   req_ar;
    logic [N-1:0]      req_ar_valid;
    logic [N-1:0]      req_ar_ready;
    logic [N-1:0]      req_r_valid;
    logic [N-1:0]      req_r_ready;
    logic [DW-1:0]     req_r_data;
    logic [N-1:0]      req_flush;
    logic [AW-1:0]     bus_ar;
    logic              bus_ar_valid;
    logic              bus_ar_ready;
    logic              bus_r_valid;
    logic              bus_r_ready;
    logic [DW-1:0]     bus_r_data;
    logic [RB-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    ifu_fetch_arb #(.NUM_REQ(N), .REQ_BITS(RB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_ar(req_ar), .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready),
        .req_r_valid(req_r_valid), .req_r_ready(req_r_ready), .req_r_data(req_r_data),
        .req_flush(req_flush),
        .bus_ar(bus_ar), .bus_ar_valid(bus_ar_valid), .bus_ar_ready(bus_ar_ready),
        .bus_r_valid(bus_r_valid), .bus_r_ready(bus_r_ready), .bus_r_data(bus_r_data),
        .grant_id(grant_id), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one open transaction record plus round-robin pointer.
    bit            m_open, m_ar_pend, m_cancel;
    int            m_owner, m_last, m_gid;
    logic [AW-1:0] m_addr;
    int            grants [N];
    int            n_deliv;
    int            w;
    logic [N-1:0]  exp_rdy, exp_rv;
    bit            exp_brr, in_data, own_flush, m_ar_hs, m_r_hs;

    // Bus-side responder.
    bit            r_active, ar_hs_dut, r_hs_dut;
    int            r_delay;
    logic [DW-1:0] r_line;
    logic [AW-1:0] ar_cap;
    logic [N-1:0]  rdy_cap;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_ar       = '0;
        req_ar_valid = '0;
        req_r_ready  = '0;
        req_flush    = '0;
        bus_ar_ready = 1'b0;
        bus_r_valid  = 1'b0;
        bus_r_data   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {a, ~a, a[31:0] ^ 32'hC0DE_F00D};
    endfunction

    // First valid requester after 'last', wrapping; -1 when none.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[RB'((last + k) % N)]) return (last + k) % N;
        end
        return -1;
    endfunction

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_bus_ar_valid", bus_ar_valid, 0);
        chk("rst_bus_ar", bus_ar, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_ar_ready", req_ar_ready, 0);
        chk("rst_r_valid", req_r_valid, 0);
        chk("rst_bus_r_ready", bus_r_ready, 0);
        chk("rst_r_data", req_r_data, 0);

        // ---------------- single transaction ----------------
        req_ar[0*AW +: AW] = 48'h1000;
        req_ar_valid = 4'b0001;
        settle();
        chk("t1_ar_ready", req_ar_ready, 4'b0001);
        tick();
        req_ar_valid = '0;
        settle();
        chk("t1_bus_ar", bus_ar, 48'h1000);
        chk("t1_bus_ar_valid", bus_ar_valid, 1);
        chk("t1_grant_id", grant_id, 0);
        chk("t1_busy", busy, 1);
        chk("t1_ar_ready_addr", req_ar_ready, 0);
        bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0;
        bus_r_valid  = 1'b1;
        bus_r_data   = {16{8'hA5}};
        req_r_ready  = 4'b0001;
        settle();
        chk("t1_bus_ar_valid_data", bus_ar_valid, 0);
        chk("t1_r_valid", req_r_valid, 4'b0001);
        chk("t1_r_data", req_r_data, {16{8'hA5}});
        chk("t1_bus_r_ready", bus_r_ready, 1);
        tick();
        bus_r_valid = 1'b0;
        req_r_ready = '0;
        settle();
        chk("t1_idle", busy, 0);

        // ---------------- round-robin with all valid ----------------
        do_reset();
        for (int i = 0; i < N; i++) req_ar[i*AW +: AW] = AW'(48'h100 * (i + 1));
        req_ar_valid = '1;
        for (int n = 0; n < 5; n++) begin
            settle();
            chk("rr_ar_ready", req_ar_ready, N'(1) << (n % N));
            tick();
            chk("rr_grant_id", grant_id, n % N);
            chk("rr_bus_ar", bus_ar, 48'h100 * ((n % N) + 1));
            chk("rr_no_ready_addr", req_ar_ready, 0);
            bus_ar_ready = 1'b1;
            tick();
            bus_ar_ready = 1'b0;
            bus_r_valid  = 1'b1;
            req_r_ready  = '1;
            settle();
            chk("rr_r_valid", req_r_valid, N'(1) << (n % N));
            chk("rr_no_ready_data", req_ar_ready, 0);
            tick();
            bus_r_valid = 1'b0;
            req_r_ready = '0;
        end
        req_ar_valid = '0;

        // ---------------- AR stall: last grant was 0, requester 1 wins ----------------
        req_ar[1*AW +: AW] = 48'hABC;
        req_ar_valid = 4'b0010;
        settle();
        chk("stall_ar_ready", req_ar_ready, 4'b0010);
        tick();
        req_ar[2*AW +: AW] = 48'hDEF;
        req_ar_valid = 4'b0100;
        for (int n = 0; n < 5; n++) begin
            settle();
            chk("stall_bus_ar", bus_ar, 48'hABC);
            chk("stall_bus_ar_valid", bus_ar_valid, 1);
            chk("stall_no_ready", req_ar_ready, 0);
            tick();
        end
        bus_ar_ready = 1'b1;
        req_ar_valid = '0;
        tick();
        bus_ar_ready = 1'b0;
        bus_r_valid  = 1'b1;
        req_r_ready  = '1;
        tick();
        bus_r_valid = 1'b0;
        req_r_ready = '0;

        // ---------------- owner 2 flushes in ADDR ----------------
        req_ar[2*AW +: AW] = 48'h2000;
        req_ar_valid = 4'b0100;
        settle();
        chk("flush_ar_ready", req_ar_ready, 4'b0100);
        tick();
        req_ar_valid = '0;
        req_flush    = 4'b0100;
        bus_ar_ready = 1'b1;
        tick();
        req_flush    = '0;
        bus_ar_ready = 1'b0;
        bus_r_valid  = 1'b1;
        bus_r_data   = {4{32'h1234_5678}};
        req_r_ready  = '0;
        settle();
        chk("flush_bus_r_ready", bus_r_ready, 1);
        chk("flush_r_valid", req_r_valid, 0);
        tick();
        bus_r_valid = 1'b0;
        settle();
        chk("flush_idle", busy, 0);
        req_ar[2*AW +: AW] = 48'h2040;
        req_ar_valid = 4'b0100;
        settle();
        chk("flush_regrant", req_ar_ready, 4'b0100);
        tick();
        req_ar_valid = '0;
        bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0;
        bus_r_valid  = 1'b1;
        req_r_ready  = 4'b0100;
        settle();
        chk("flush_regrant_r_valid", req_r_valid, 4'b0100);
        tick();
        bus_r_valid = 1'b0;
        req_r_ready = '0;

        // ---------------- R backpressure on owner 3 ----------------
        req_ar[3*AW +: AW] = 48'h3000;
        req_ar_valid = 4'b1000;
        settle();
        chk("bp_ar_ready", req_ar_ready, 4'b1000);
        tick();
        req_ar_valid = '0;
        bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0;
        bus_r_valid  = 1'b1;
        req_r_ready  = 4'b0111;
        for (int n = 0; n < 3; n++) begin
            settle();
            chk("bp_bus_r_ready", bus_r_ready, 0);
            chk("bp_r_valid", req_r_valid, 4'b1000);
            tick();
        end
        req_r_ready = 4'b1000;
        settle();
        chk("bp_bus_r_ready_go", bus_r_ready, 1);
        tick();
        bus_r_valid = 1'b0;
        req_r_ready = '0;
        settle();
        chk("bp_idle", busy, 0);

        // ---------------- reset during DATA ----------------
        req_ar_valid = 4'b0010;
        settle();
        chk("rd_ar_ready", req_ar_ready, 4'b0010);
        tick();
        req_ar_valid = '0;
        bus_ar_ready = 1'b1;
        tick();
        bus_ar_ready = 1'b0;
        settle();
        chk("rd_busy_data", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rd_busy", busy, 0);
        chk("rd_bus_ar_valid", bus_ar_valid, 0);
        chk("rd_grant_id", grant_id, 0);
        req_ar_valid = 4'b0011;
        settle();
        chk("rd_first_prio", req_ar_ready, 4'b0001);

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        m_open = 0; m_ar_pend = 0; m_cancel = 0;
        m_owner = 0; m_last = N - 1; m_gid = 0; m_addr = '0;
        n_deliv = 0;
        for (int i = 0; i < N; i++) grants[i] = 0;
        r_active = 0; r_delay = 0; r_line = '0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_ar_valid[i] && ($urandom % 4 == 0)) begin
                    req_ar_valid[i]    = 1'b1;
                    req_ar[i*AW +: AW] = AW'({$urandom, $urandom});
                end
                req_flush[i] = ($urandom % 14 == 0);
            end
            req_r_ready  = N'($urandom);
            bus_ar_ready = ($urandom % 2 == 0);
            bus_r_valid  = r_active && (r_delay == 0);
            bus_r_data   = bus_r_valid ? r_line : {4{$urandom}};
            settle();

            w       = m_open ? -1 : rr_pick(req_ar_valid, m_last);
            exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
            in_data   = m_open && !m_ar_pend;
            own_flush = m_open && req_flush[RB'(m_owner)];
            exp_rv  = (in_data && bus_r_valid && !m_cancel && !own_flush) ? (N'(1) << m_owner) : '0;
            exp_brr = in_data && (m_cancel || own_flush || req_r_ready[RB'(m_owner)]);

            chk("rnd_ar_ready", req_ar_ready, exp_rdy);
            chk("rnd_busy", busy, m_open);
            chk("rnd_bus_ar_valid", bus_ar_valid, m_open && m_ar_pend);
            if (m_open && m_ar_pend) chk("rnd_bus_ar", bus_ar, m_addr);
            chk("rnd_grant_id", grant_id, m_gid);
            chk("rnd_r_valid", req_r_valid, exp_rv);
            chk("rnd_bus_r_ready", bus_r_ready, exp_brr);
            if (exp_rv != 0) chk("rnd_r_data", req_r_data, line_of(m_addr));
            if (!m_open) chk("rnd_r_data_idle", req_r_data, 0);

            m_ar_hs   = m_open && m_ar_pend && bus_ar_ready;
            m_r_hs    = in_data && bus_r_valid && exp_brr;
            ar_hs_dut = bus_ar_valid && bus_ar_ready;
            r_hs_dut  = bus_r_valid && bus_r_ready;
            ar_cap    = bus_ar;
            rdy_cap   = req_ar_ready;
            if (exp_rv != 0 && req_r_ready[RB'(m_owner)]) n_deliv++;
            if (w >= 0) m_addr = req_ar[w*AW +: AW];

            tick();

            if (w >= 0) begin
                m_open    = 1;
                m_ar_pend = 1;
                m_owner   = w;
                m_gid     = w;
                m_last    = w;
                m_cancel  = req_flush[RB'(w)];
                grants[w]++;
            end else if (m_open) begin
                if (own_flush) m_cancel = 1;
                if (m_ar_hs) m_ar_pend = 0;
                if (m_r_hs) begin
                    m_open   = 0;
                    m_cancel = 0;
                end
            end
            req_ar_valid = req_ar_valid & ~rdy_cap;

            if (r_hs_dut) r_active = 0;
            else if (r_active && r_delay > 0) r_delay--;
            if (ar_hs_dut) begin
                r_active = 1;
                r_delay  = int'($urandom % 4);
                r_line   = line_of(ar_cap);
            end
        end

        chk("rnd_deliveries", n_deliv > 0, 1);
        for (int i = 0; i < N; i++) chk("rnd_fair_grant", grants[i] > 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
